// File: rtl/layer_priority_mux.sv
// Fixed-priority N-layer pixel compositor with two-stage pipeline and per-frame overlap reporting.
// Optional macro LAYER_COLLISION_EN enables collisionNow/collisionFrame; otherwise they are tied to 0.
module layer_priority_mux #(
    parameter int N_LAYERS = 4,
    parameter int RGB_W = 8,
    parameter logic [RGB_W-1:0] TRANSPARENT = RGB_W'(8'hFF),
    localparam int TL_W = $clog2(N_LAYERS + 1)
) (
    input  logic                      clk,
    input  logic                      resetN,
    input  logic [N_LAYERS-1:0]       drawingRequest,
    input  logic [N_LAYERS*RGB_W-1:0] layerRGB,
    input  logic [N_LAYERS-1:0]       layerEnable,
    input  logic                      BGDrawingRequest,
    input  logic [RGB_W-1:0]          backGroundRGB,
    input  logic [RGB_W-1:0]          RGB_MIF,
    input  logic                      startOfFrame,
    output logic [RGB_W-1:0]          RGBOut,
    output logic [TL_W-1:0]           topLayer,
    output logic                      collisionNow,
    output logic [N_LAYERS-1:0]       collisionFrame
);

    logic [N_LAYERS-1:0]       eff;
    logic [N_LAYERS-1:0]       eff_q;
    logic [N_LAYERS*RGB_W-1:0] rgb_q;
    logic                      bg_req_q;
    logic [RGB_W-1:0]          bg_rgb_q;
    logic [RGB_W-1:0]          mif_q;
    logic [RGB_W-1:0]          sel_rgb;
    logic [TL_W-1:0]           sel_top;

    // A layer only counts when requested, enabled and not showing the colour key.
    always_comb begin
        eff = '0;
        for (int i = 0; i < N_LAYERS; i++) begin
            eff[i] = drawingRequest[i] & layerEnable[i]
                     & (layerRGB[i*RGB_W +: RGB_W] != TRANSPARENT);
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            eff_q    <= '0;
            rgb_q    <= '0;
            bg_req_q <= 1'b0;
            bg_rgb_q <= '0;
            mif_q    <= '0;
        end else begin
            eff_q    <= eff;
            rgb_q    <= layerRGB;
            bg_req_q <= BGDrawingRequest;
            bg_rgb_q <= backGroundRGB;
            mif_q    <= RGB_MIF;
        end
    end

    // Descending scan so the lowest active index is the last (winning) assignment.
    always_comb begin
        sel_rgb = bg_req_q ? bg_rgb_q : mif_q;
        sel_top = TL_W'(N_LAYERS);
        for (int i = N_LAYERS - 1; i >= 0; i--) begin
            if (eff_q[i]) begin
                sel_rgb = rgb_q[i*RGB_W +: RGB_W];
                sel_top = TL_W'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            RGBOut   <= '0;
            topLayer <= '0;
        end else begin
            RGBOut   <= sel_rgb;
            topLayer <= sel_top;
        end
    end

`ifdef LAYER_COLLISION_EN
    logic                sof_q;
    logic                coll;
    logic [N_LAYERS-1:0] col_acc;

    // Two or more bits set <=> clearing the lowest set bit leaves something.
    assign coll = |(eff_q & (eff_q - N_LAYERS'(1)));

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            sof_q <= 1'b0;
        end else begin
            sof_q <= startOfFrame;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            collisionNow   <= 1'b0;
            collisionFrame <= '0;
            col_acc        <= '0;
        end else begin
            collisionNow <= coll;
            if (sof_q) begin
                // First pixel of the new frame belongs to the new accumulation.
                collisionFrame <= col_acc;
                col_acc        <= coll ? eff_q : '0;
            end else if (coll) begin
                col_acc <= col_acc | eff_q;
            end
        end
    end
`else
    logic unused_sof;
    assign unused_sof     = startOfFrame;
    assign collisionNow   = 1'b0;
    assign collisionFrame = '0;
`endif

endmodule
